cpu_side_cache_controller: RTL and testbench
============================================

Name: cpu_side_cache_controller

Overview:
CPU-side sequencer for the direct-mapped snoopy cache array (MSI protocol). Accepts one CPU read/write at a time, resolves hits against the array's CPU port, and on a miss wins the shared bus, writes back a MODIFIED victim line and refills the line word by word. Write hits on SHARED lines broadcast a bus invalidate before updating. The snoopy-side controller owns the array's snoop port and is out of scope.

Parameters:
ADDRESS_WIDTH  16  CPU/memory word address width
DATA_WIDTH     16  word width
TAG_WIDTH      8   tag field, address[15:8]
INDEX_WIDTH    4   line index, address[7:4]
OFFSET_WIDTH   4   word-in-line, address[3:0]; words per line = 2^OFFSET_WIDTH
Constraint: TAG_WIDTH + INDEX_WIDTH + OFFSET_WIDTH == ADDRESS_WIDTH.

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low
cpuRead / cpuWrite  in  1 / 1  CPU request, held stable until cpuDone
cpuAddress  in  ADDRESS_WIDTH  request address
cpuDataIn  in  DATA_WIDTH  write data
cpuDataOut  out  DATA_WIDTH  read data, valid when cpuDone
cpuDone  out  1  request complete, one-cycle pulse
cacheTag / cacheIndex / cacheOffset  out  TAG/INDEX/OFFSET  array CPU-port address
cacheHit  in  1  array hit (tag match, state != INVALID)
cacheTagOut  in  TAG_WIDTH  stored tag at cacheIndex
cacheStateOut  in  2  stored state at cacheIndex
cacheDataOut  in  DATA_WIDTH  stored word
cacheStateIn / cacheDataIn  out  2 / DATA_WIDTH  array write values
cacheWriteTag / cacheWriteState / cacheWriteData  out  1 each  array write enables
busRequest  out  1  bus arbitration request
busGrant  in  1  bus owned while high
busInvalidate  out  1  one-cycle invalidate broadcast, address on memAddress
memRead / memWrite  out  1 / 1  word transfer, held until memDone
memReadExclusive  out  1  qualifies memRead for write-miss refill
memAddress  out  ADDRESS_WIDTH  transfer address
memDataOut  out  DATA_WIDTH  write-back data
memDataIn  in  DATA_WIDTH  refill data
memDone  in  1  transfer word complete

Behaviour:
- States: IDLE, WAIT_GRANT, INVALIDATE, WRITE_BACK, FETCH, FINISH. MSI encoding INVALID=0, SHARED=1, MODIFIED=2.
- Reset (reset==0, async): state IDLE, counter 0, every output 0. Reset mid-transfer abandons it; no array write is issued afterwards.
- cacheTag/Index/Offset follow cpuAddress in IDLE/INVALIDATE/FINISH; cacheOffset = word counter in WRITE_BACK/FETCH.
- IDLE, read hit: cpuDone=1 and cpuDataOut=cacheDataOut the same cycle (zero-wait hit).
- IDLE, write hit MODIFIED: cacheWriteData=1, cpuDone=1 the same cycle.
- IDLE, write hit SHARED, or any miss: busRequest=1 next cycle -> WAIT_GRANT. busRequest stays high until leaving FINISH.
- WAIT_GRANT on busGrant: upgrade -> INVALIDATE; miss with cacheStateOut==MODIFIED -> WRITE_BACK; else -> FETCH. Counter cleared.
- INVALIDATE: busInvalidate=1 for exactly one cycle; writes state MODIFIED and the data word; cpuDone=1; -> IDLE.
- WRITE_BACK: memWrite=1, memAddress={cacheTagOut, index, counter}, memDataOut=cacheDataOut; on memDone counter++; after last word (counter wraps to 0) -> FETCH.
- FETCH: memRead=1, memReadExclusive=cpuWrite, memAddress={cpuTag, index, counter}; on memDone cacheWriteData=1 with memDataIn at counter; after last word -> FINISH.
- FINISH: cacheWriteTag=1, cacheWriteState=1 with SHARED (read) or MODIFIED (write); next cycle IDLE, where the retried access hits.
- busGrant deasserted mid-burst is a protocol violation; the controller does not re-arbitrate.
- cpuRead and cpuWrite both high: treated as write.
- Counter is OFFSET_WIDTH bits; the wrap from all-ones to 0 marks the last word.

Decomposition:
- Shared package cache_pkg: MSI state typedef and constants, controller state enum, field-width localparams.
- One sub-module: line_word_counter (OFFSET_WIDTH counter with clear, increment, last-word flag).

Test Plan:
- Read miss, empty cache, addr 0x1234: bus requested, 16 FETCH words from 0x1230..0x123F, tag 0x12 written, state SHARED; then cpuDone with the word at 0x1234.
- Write hit on SHARED line at 0x1234, data 0xBEEF: one busInvalidate pulse, state becomes MODIFIED, re-read returns 0xBEEF.
- Write miss 0x5634 evicting MODIFIED 0x1234 line: 16 memWrite to 0x1230..0x123F, then memReadExclusive refill of 0x5630..0x563F, final state MODIFIED.
- Read hit on a MODIFIED line: cpuDone in the same cycle as the request, no bus activity.
- busGrant delayed 5 cycles: busRequest held, no mem strobes until grant.
- reset low during FETCH word 7: all outputs 0 immediately, no tag/state write; the next read at the same address is a miss again.

Source files
------------

// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared types and field widths for the CPU-side cache controller
//
// Purpose: MSI line-state encoding, controller state enum and address field widths
// shared by the controller top and its word counter.
// Ports: none (package).

package cache_pkg;

  localparam int ADDRESS_WIDTH = 16;
  localparam int DATA_WIDTH    = 16;
  localparam int TAG_WIDTH     = 8;
  localparam int INDEX_WIDTH   = 4;
  localparam int OFFSET_WIDTH  = 4;

  // MSI coherence state of a cache line, as stored in the array.
  typedef enum logic [1:0] {
    INVALID  = 2'd0,
    SHARED   = 2'd1,
    MODIFIED = 2'd2
  } msi_state_e;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_GRANT = 3'd1,
    INVALIDATE = 3'd2,
    WRITE_BACK = 3'd3,
    FETCH      = 3'd4,
    FINISH     = 3'd5
  } ctrl_state_e;

endpackage

// File: rtl/line_word_counter.sv
// rtl/line_word_counter.sv - word-in-line counter for write-back and refill bursts
//
// Purpose: OFFSET_WIDTH-bit counter stepping through the words of one line.
// Ports:
//   clock, reset     rising-edge clock, asynchronous active-low reset
//   clear            synchronous clear to word 0 (wins over increment)
//   increment        advance by one word
//   count            current word offset
//   last             count is the final word of the line (all ones)

module line_word_counter
  import cache_pkg::*;
(
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    increment,
  output logic [OFFSET_WIDTH-1:0] count,
  output logic                    last
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (increment) begin
      count <= count + 1'b1;
    end
  end

  // Incrementing from the last word wraps to 0, ready for the next burst.
  assign last = &count;

endmodule

// File: rtl/cpu_side_cache_controller.sv
// rtl/cpu_side_cache_controller.sv - CPU-side MSI sequencer for a direct-mapped snoopy cache
//
// Purpose: serves one CPU read/write at a time against the array CPU port; on a miss
// arbitrates for the bus, writes back a MODIFIED victim and refills the line; on a
// write hit to a SHARED line broadcasts a bus invalidate before updating.
// Ports:
//   clock, reset                          clock, asynchronous active-low reset
//   cpuRead/cpuWrite/cpuAddress/cpuDataIn CPU request, held until cpuDone
//   cpuDataOut/cpuDone                    read data and one-cycle completion pulse
//   cacheTag/cacheIndex/cacheOffset       array CPU-port address
//   cacheHit/cacheTagOut/cacheStateOut/cacheDataOut   array read side
//   cacheStateIn/cacheDataIn/cacheWrite*  array write side
//   busRequest/busGrant/busInvalidate     bus arbitration and invalidate broadcast
//   memRead/memWrite/memReadExclusive/memAddress/memDataOut/memDataIn/memDone
//                                         word-by-word memory transfers

module cpu_side_cache_controller
  import cache_pkg::*;
(
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     cpuRead,
  input  logic                     cpuWrite,
  input  logic [ADDRESS_WIDTH-1:0] cpuAddress,
  input  logic [DATA_WIDTH-1:0]    cpuDataIn,
  output logic [DATA_WIDTH-1:0]    cpuDataOut,
  output logic                     cpuDone,
  output logic [TAG_WIDTH-1:0]     cacheTag,
  output logic [INDEX_WIDTH-1:0]   cacheIndex,
  output logic [OFFSET_WIDTH-1:0]  cacheOffset,
  input  logic                     cacheHit,
  input  logic [TAG_WIDTH-1:0]     cacheTagOut,
  input  logic [1:0]               cacheStateOut,
  input  logic [DATA_WIDTH-1:0]    cacheDataOut,
  output logic [1:0]               cacheStateIn,
  output logic [DATA_WIDTH-1:0]    cacheDataIn,
  output logic                     cacheWriteTag,
  output logic                     cacheWriteState,
  output logic                     cacheWriteData,
  output logic                     busRequest,
  input  logic                     busGrant,
  output logic                     busInvalidate,
  output logic                     memRead,
  output logic                     memWrite,
  output logic                     memReadExclusive,
  output logic [ADDRESS_WIDTH-1:0] memAddress,
  output logic [DATA_WIDTH-1:0]    memDataOut,
  input  logic [DATA_WIDTH-1:0]    memDataIn,
  input  logic                     memDone
);

  ctrl_state_e state, state_next;

  logic [TAG_WIDTH-1:0]    cpu_tag;
  logic [INDEX_WIDTH-1:0]  cpu_index;
  logic [OFFSET_WIDTH-1:0] cpu_offset;
  logic [OFFSET_WIDTH-1:0] word_count;
  logic                    word_last;
  logic                    count_clear;
  logic                    count_inc;
  logic                    request;
  logic                    hit_complete;

  assign {cpu_tag, cpu_index, cpu_offset} = cpuAddress;
  // A simultaneous read and write is served as a write.
  assign request      = cpuRead | cpuWrite;
  // Hits that finish in IDLE: any read hit, or a write hit that already owns the line.
  assign hit_complete = cacheHit & (~cpuWrite | (cacheStateOut == MODIFIED));

  assign count_clear = (state == IDLE) || (state == WAIT_GRANT);
  assign count_inc   = memDone && ((state == WRITE_BACK) || (state == FETCH));

  line_word_counter u_word_counter (
    .clock     (clock),
    .reset     (reset),
    .clear     (count_clear),
    .increment (count_inc),
    .count     (word_count),
    .last      (word_last)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:       if (request && !hit_complete) state_next = WAIT_GRANT;
      // The hit is re-evaluated at grant time: a snooped invalidate while waiting
      // turns an upgrade into an ordinary miss.
      WAIT_GRANT: if (busGrant) begin
                    if (cacheHit)                       state_next = INVALIDATE;
                    else if (cacheStateOut == MODIFIED) state_next = WRITE_BACK;
                    else                                state_next = FETCH;
                  end
      INVALIDATE: state_next = IDLE;
      WRITE_BACK: if (memDone && word_last) state_next = FETCH;
      FETCH:      if (memDone && word_last) state_next = FINISH;
      FINISH:     state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  // Outputs are forced low while reset is held so nothing reaches the array or bus
  // even combinationally.
  always_comb begin
    cpuDataOut       = '0;
    cpuDone          = 1'b0;
    cacheTag         = '0;
    cacheIndex       = '0;
    cacheOffset      = '0;
    cacheStateIn     = INVALID;
    cacheDataIn      = '0;
    cacheWriteTag    = 1'b0;
    cacheWriteState  = 1'b0;
    cacheWriteData   = 1'b0;
    busRequest       = 1'b0;
    busInvalidate    = 1'b0;
    memRead          = 1'b0;
    memWrite         = 1'b0;
    memReadExclusive = 1'b0;
    memAddress       = '0;
    memDataOut       = '0;
    if (reset) begin
      cacheTag    = cpu_tag;
      cacheIndex  = cpu_index;
      cacheOffset = cpu_offset;
      case (state)
        IDLE: begin
          if (request && hit_complete) begin
            cpuDone = 1'b1;
            if (cpuWrite) begin
              cacheWriteData = 1'b1;
              cacheDataIn    = cpuDataIn;
            end else begin
              cpuDataOut = cacheDataOut;
            end
          end
        end
        WAIT_GRANT: busRequest = 1'b1;
        INVALIDATE: begin
          busRequest      = 1'b1;
          busInvalidate   = 1'b1;
          memAddress      = cpuAddress;
          cacheWriteState = 1'b1;
          cacheStateIn    = MODIFIED;
          cacheWriteData  = 1'b1;
          cacheDataIn     = cpuDataIn;
          cpuDone         = 1'b1;
        end
        WRITE_BACK: begin
          busRequest  = 1'b1;
          memWrite    = 1'b1;
          cacheOffset = word_count;
          memAddress  = {cacheTagOut, cpu_index, word_count};
          memDataOut  = cacheDataOut;
        end
        FETCH: begin
          busRequest       = 1'b1;
          memRead          = 1'b1;
          memReadExclusive = cpuWrite;
          cacheOffset      = word_count;
          memAddress       = {cpu_tag, cpu_index, word_count};
          if (memDone) begin
            cacheWriteData = 1'b1;
            cacheDataIn    = memDataIn;
          end
        end
        FINISH: begin
          busRequest      = 1'b1;
          cacheWriteTag   = 1'b1;
          cacheWriteState = 1'b1;
          cacheStateIn    = cpuWrite ? MODIFIED : SHARED;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_side_cache_controller.sv
// tb/tb_cpu_side_cache_controller.sv - scoreboard bench for the CPU-side cache controller

module tb_cpu_side_cache_controller;

  localparam logic [2:0] EV_MRD  = 3'd1;  // completed refill word: addr, data = exclusive flag
  localparam logic [2:0] EV_MWR  = 3'd2;  // completed write-back word: addr, data
  localparam logic [2:0] EV_INV  = 3'd3;  // invalidate broadcast: addr
  localparam logic [2:0] EV_TAG  = 3'd4;  // tag+state write: addr = {tag,index,0}, data = state
  localparam logic [2:0] EV_ST   = 3'd5;  // state-only write: addr, data = state
  localparam logic [2:0] EV_DRD  = 3'd6;  // read done: addr, data
  localparam logic [2:0] EV_DWR  = 3'd7;  // write done: addr

  typedef struct packed {
    logic [2:0]  kind;
    logic [15:0] addr;
    logic [15:0] data;
  } ev_t;

  logic        clock;
  logic        reset;
  logic        cpuRead, cpuWrite;
  logic [15:0] cpuAddress, cpuDataIn, cpuDataOut;
  logic        cpuDone;
  logic [7:0]  cacheTag;
  logic [3:0]  cacheIndex, cacheOffset;
  logic        cacheHit;
  logic [7:0]  cacheTagOut;
  logic [1:0]  cacheStateOut, cacheStateIn;
  logic [15:0] cacheDataOut, cacheDataIn;
  logic        cacheWriteTag, cacheWriteState, cacheWriteData;
  logic        busRequest, busGrant, busInvalidate;
  logic        memRead, memWrite, memReadExclusive;
  logic [15:0] memAddress, memDataOut, memDataIn;
  logic        memDone;

  ev_t exp_q[$];
  int  passed = 0;
  int  total  = 0;
  int  grant_delay = 0;

  logic [15:0] mem [logic [15:0]];
  logic [7:0]  tag_arr [16]  = '{default: '0};
  logic [1:0]  st_arr  [16]  = '{default: '0};
  logic [15:0] dat_arr [256] = '{default: '0};

  cpu_side_cache_controller dut (
    .clock(clock), .reset(reset),
    .cpuRead(cpuRead), .cpuWrite(cpuWrite), .cpuAddress(cpuAddress), .cpuDataIn(cpuDataIn),
    .cpuDataOut(cpuDataOut), .cpuDone(cpuDone),
    .cacheTag(cacheTag), .cacheIndex(cacheIndex), .cacheOffset(cacheOffset),
    .cacheHit(cacheHit), .cacheTagOut(cacheTagOut), .cacheStateOut(cacheStateOut),
    .cacheDataOut(cacheDataOut), .cacheStateIn(cacheStateIn), .cacheDataIn(cacheDataIn),
    .cacheWriteTag(cacheWriteTag), .cacheWriteState(cacheWriteState), .cacheWriteData(cacheWriteData),
    .busRequest(busRequest), .busGrant(busGrant), .busInvalidate(busInvalidate),
    .memRead(memRead), .memWrite(memWrite), .memReadExclusive(memReadExclusive),
    .memAddress(memAddress), .memDataOut(memDataOut), .memDataIn(memDataIn), .memDone(memDone)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Direct-mapped array model (the array itself is outside the controller).
  always_comb begin
    cacheTagOut   = tag_arr[cacheIndex];
    cacheStateOut = st_arr[cacheIndex];
    cacheHit      = (st_arr[cacheIndex] != 2'd0) && (tag_arr[cacheIndex] == cacheTag);
    cacheDataOut  = dat_arr[{cacheIndex, cacheOffset}];
  end

  always @(posedge clock) begin
    if (cacheWriteTag)   tag_arr[cacheIndex] <= cacheTag;
    if (cacheWriteState) st_arr[cacheIndex]  <= cacheStateIn;
    if (cacheWriteData)  dat_arr[{cacheIndex, cacheOffset}] <= cacheDataIn;
  end

  // Unwritten memory holds addr ^ 16'hA5A5.
  function automatic logic [15:0] mem_read(input logic [15:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 16'hA5A5;
  endfunction

  // Memory responder (two-cycle latency, one-cycle memDone) and bus arbiter.
  initial begin
    int lat;
    int gcnt;
    lat = 0; gcnt = 0;
    memDone = 1'b0; memDataIn = '0; busGrant = 1'b0;
    forever begin
      @(posedge clock); #2;
      if (!reset) begin
        memDone = 1'b0; lat = 0; busGrant = 1'b0; gcnt = 0;
      end else begin
        if (!busRequest) begin
          busGrant = 1'b0; gcnt = 0;
        end else if (!busGrant) begin
          if (gcnt >= grant_delay) busGrant = 1'b1;
          else gcnt++;
        end
        memDataIn = mem_read(memAddress);
        if (memDone) begin
          memDone = 1'b0; lat = 0;
        end else if (memRead || memWrite) begin
          lat++;
          if (lat >= 2) begin
            memDone = 1'b1;
            if (memWrite) mem[memAddress] = memDataOut;
          end
        end
      end
    end
  end

  task automatic push(input logic [2:0] kind, input logic [15:0] addr, input logic [15:0] data);
    ev_t e;
    e.kind = kind; e.addr = addr; e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic sb_check(input logic [2:0] kind, input logic [15:0] addr, input logic [15:0] data);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      $display("FAIL sb_unexpected: got kind=%0d addr=%h data=%h, required no event", kind, addr, data);
    end else begin
      e = exp_q.pop_front();
      if (e.kind == kind && e.addr == addr && e.data == data) passed++;
      else $display("FAIL sb_event: got kind=%0d addr=%h data=%h, required kind=%0d addr=%h data=%h",
                    kind, addr, data, e.kind, e.addr, e.data);
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  // Monitor: every DUT-presented event is compared against the expected queue.
  initial forever begin
    @(negedge clock);
    if (reset) begin
      if (memDone && memRead)  sb_check(EV_MRD, memAddress, {15'b0, memReadExclusive});
      if (memDone && memWrite) sb_check(EV_MWR, memAddress, memDataOut);
      if (busInvalidate)       sb_check(EV_INV, memAddress, 16'h0);
      if (cacheWriteTag)       sb_check(EV_TAG, {cacheTag, cacheIndex, 4'h0}, {14'b0, cacheStateIn});
      else if (cacheWriteState) sb_check(EV_ST, {cacheTag, cacheIndex, cacheOffset}, {14'b0, cacheStateIn});
      if (cpuDone) begin
        if (cpuWrite) sb_check(EV_DWR, cpuAddress, 16'h0);
        else          sb_check(EV_DRD, cpuAddress, cpuDataOut);
      end
    end
  end

  task automatic start_req(input logic wr, input logic [15:0] a, input logic [15:0] d);
    @(posedge clock); #2;
    cpuAddress = a; cpuDataIn = d; cpuWrite = wr; cpuRead = ~wr;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    forever begin
      @(negedge clock);
      if (cpuDone) break;
      cycles++;
      if (cycles > 600) begin
        total++;
        $display("FAIL cpu_done_timeout: got no cpuDone in %0d cycles, required cpuDone", cycles);
        break;
      end
    end
  endtask

  task automatic end_req();
    @(posedge clock); #2;
    cpuRead = 1'b0; cpuWrite = 1'b0;
  endtask

  task automatic cpu_req(input logic wr, input logic [15:0] a, input logic [15:0] d, output int cycles);
    start_req(wr, a, d);
    wait_done(cycles);
    end_req();
  endtask

  function automatic logic [90:0] all_outputs();
    return {cpuDataOut, cpuDone, cacheTag, cacheIndex, cacheOffset, cacheStateIn, cacheDataIn,
            cacheWriteTag, cacheWriteState, cacheWriteData, busRequest, busInvalidate,
            memRead, memWrite, memReadExclusive, memAddress, memDataOut};
  endfunction

  initial begin
    int cyc;
    int wait_cnt;
    logic strobe_seen;
    logic found;
    reset = 1'b0; cpuRead = 1'b1; cpuWrite = 1'b0; cpuAddress = 16'h1234; cpuDataIn = 16'h0;

    // Reset with a request pending: every output must stay 0.
    repeat (3) @(negedge clock);
    check("reset_outputs_zero", {31'b0, |all_outputs()}, 32'h0);
    @(posedge clock); #2;
    cpuRead = 1'b0; reset = 1'b1;

    // Read miss on an empty cache.
    for (int i = 0; i < 16; i++) push(EV_MRD, 16'h1230 + i[15:0], 16'h0);
    push(EV_TAG, 16'h1230, 16'd1);
    push(EV_DRD, 16'h1234, 16'hB791);
    cpu_req(1'b0, 16'h1234, 16'h0, cyc);

    // Write hit on the SHARED line: upgrade through an invalidate.
    push(EV_INV, 16'h1234, 16'h0);
    push(EV_ST, 16'h1234, 16'd2);
    push(EV_DWR, 16'h1234, 16'h0);
    cpu_req(1'b1, 16'h1234, 16'hBEEF, cyc);

    // Read hits on the now-MODIFIED line complete in the request cycle.
    push(EV_DRD, 16'h1234, 16'hBEEF);
    cpu_req(1'b0, 16'h1234, 16'h0, cyc);
    check("hit_zero_wait", cyc, 0);
    push(EV_DRD, 16'h1235, 16'hB790);
    start_req(1'b0, 16'h1235, 16'h0);
    wait_done(cyc);
    check("hit_no_bus_request", {31'b0, busRequest}, 32'h0);
    end_req();

    // Write miss evicting the MODIFIED line, with a 5-cycle grant delay.
    grant_delay = 5;
    for (int i = 0; i < 16; i++)
      push(EV_MWR, 16'h1230 + i[15:0], (i == 4) ? 16'hBEEF : ((16'h1230 + i[15:0]) ^ 16'hA5A5));
    for (int i = 0; i < 16; i++) push(EV_MRD, 16'h5630 + i[15:0], 16'h1);
    push(EV_TAG, 16'h5630, 16'd2);
    push(EV_DWR, 16'h5634, 16'h0);
    start_req(1'b1, 16'h5634, 16'h0042);
    @(negedge clock);
    wait_cnt = 0; strobe_seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (busGrant) break;
      wait_cnt++;
      if (!busRequest || memRead || memWrite || busInvalidate) strobe_seen = 1'b1;
    end
    check("grant_wait_cycles", wait_cnt, 5);
    check("grant_wait_quiet", {31'b0, strobe_seen}, 32'h0);
    wait_done(cyc);
    end_req();
    grant_delay = 0;

    push(EV_DRD, 16'h5634, 16'h0042);
    cpu_req(1'b0, 16'h5634, 16'h0, cyc);
    check("wmiss_then_hit_zero_wait", cyc, 0);
    push(EV_DRD, 16'h5635, 16'hF390);
    cpu_req(1'b0, 16'h5635, 16'h0, cyc);

    // Reset during FETCH word 7 abandons the refill.
    for (int i = 0; i < 7; i++) push(EV_MRD, 16'h7890 + i[15:0], 16'h0);
    start_req(1'b0, 16'h7894, 16'h0);
    found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      if (memRead && cacheOffset == 4'd7) begin found = 1'b1; break; end
    end
    check("reached_fetch_word7", {31'b0, found}, 32'h1);
    reset = 1'b0;
    #1;
    check("midreset_outputs_zero", {31'b0, |all_outputs()}, 32'h0);
    cpuRead = 1'b0;
    repeat (2) @(posedge clock);
    #2 reset = 1'b1;
    repeat (3) @(posedge clock);
    check("queue_empty_after_reset", exp_q.size(), 0);

    // Same address misses again: no tag/state was written.
    for (int i = 0; i < 16; i++) push(EV_MRD, 16'h7890 + i[15:0], 16'h0);
    push(EV_TAG, 16'h7890, 16'd1);
    push(EV_DRD, 16'h7894, 16'hDD31);
    cpu_req(1'b0, 16'h7894, 16'h0, cyc);
    check("miss_again_latency", {31'b0, cyc > 16}, 32'h1);

    repeat (5) @(posedge clock);
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
